pc_stack16: RTL and testbench



---
 rtl/pc_stack16.sv | 100 ++++++++++
 tb/tb_pc_stack16.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_stack16.sv
// Registered program counter with a hardware return-address stack.
// One action per enabled cycle: ret > call > br_taken > increment.
module pc_stack16 #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_en,
  input  logic                       br_taken,
  input  logic [WIDTH-1:0]           br_addr,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           pc_out,
  output logic                       stk_empty,
  output logic                       stk_full,
  output logic [$clog2(DEPTH+1)-1:0] stk_depth,
  output logic                       stk_err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [PtrW-1:0]  top_idx;
  logic [PtrW-1:0]  push_idx;
  logic             cnt_empty;
  logic             cnt_full;
  logic             push;

  assign pc_inc    = pc_q + WIDTH'(1);
  assign cnt_empty = (cnt_q == '0);
  assign cnt_full  = (cnt_q == CntW'(DEPTH));
  assign top_idx   = PtrW'(cnt_q - CntW'(1));
  assign push_idx  = PtrW'(cnt_q);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    // A new error event in the same cycle overrides err_clr.
    err_d = err_q & ~err_clr;
    push  = 1'b0;
    if (pc_en) begin
      if (ret) begin
        if (!cnt_empty) begin
          pc_d  = stack_q[top_idx];
          cnt_d = cnt_q - CntW'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (call) begin
        pc_d = br_addr;
        if (!cnt_full) begin
          push  = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (br_taken) begin
        pc_d = br_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack storage is not reset; entries at or above the count are never read.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc_out    = pc_q;
  assign stk_empty = cnt_empty;
  assign stk_full  = cnt_full;
  assign stk_depth = cnt_q;
  assign stk_err   = err_q;

endmodule

// File: tb/tb_pc_stack16.sv
// Directed self-checking bench for pc_stack16 (WIDTH=16, DEPTH=4).
module tb_pc_stack16;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        br_taken;
  logic [15:0] br_addr;
  logic        call;
  logic        ret;
  logic        err_clr;
  logic [15:0] pc_out;
  logic        stk_empty;
  logic        stk_full;
  logic [2:0]  stk_depth;
  logic        stk_err;

  int checks = 0;
  int errors = 0;

  pc_stack16 #(
    .WIDTH   (16),
    .DEPTH   (4),
    .RESET_PC(16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_en    (pc_en),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .call     (call),
    .ret      (ret),
    .err_clr  (err_clr),
    .pc_out   (pc_out),
    .stk_empty(stk_empty),
    .stk_full (stk_full),
    .stk_depth(stk_depth),
    .stk_err  (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] pc, input logic [2:0] depth,
                           input logic err);
    chk({tag, ".pc"}, 32'(pc_out), 32'(pc));
    chk({tag, ".depth"}, 32'(stk_depth), 32'(depth));
    chk({tag, ".err"}, 32'(stk_err), 32'(err));
    chk({tag, ".empty"}, 32'(stk_empty), 32'(depth == 3'd0));
    chk({tag, ".full"}, 32'(stk_full), 32'(depth == 3'd4));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_en = 1'b0; br_taken = 1'b0; br_addr = 16'h0000;
    call = 1'b0; ret = 1'b0; err_clr = 1'b0;
    #2;
    chk_state("reset", 16'h0000, 3'd0, 1'b0);
    #5;
    rst = 1'b0; pc_en = 1'b1;

    // Increment after reset
    step(); chk_state("inc1", 16'h0001, 3'd0, 1'b0);
    step(); chk_state("inc2", 16'h0002, 3'd0, 1'b0);
    step(); chk_state("inc3", 16'h0003, 3'd0, 1'b0);

    // Call/return nesting
    br_taken = 1'b1; br_addr = 16'h0010;
    step(); chk_state("br0010", 16'h0010, 3'd0, 1'b0);
    br_taken = 1'b0; call = 1'b1; br_addr = 16'h0100;
    step(); chk_state("call0100", 16'h0100, 3'd1, 1'b0);
    br_addr = 16'h0200;
    step(); chk_state("call0200", 16'h0200, 3'd2, 1'b0);
    call = 1'b0; ret = 1'b1;
    step(); chk_state("ret0101", 16'h0101, 3'd1, 1'b0);
    step(); chk_state("ret0011", 16'h0011, 3'd0, 1'b0);
    ret = 1'b0;

    // Overflow: pushes 0012, 1001, 2001, 3001
    call = 1'b1;
    br_addr = 16'h1000; step(); chk_state("fill1", 16'h1000, 3'd1, 1'b0);
    br_addr = 16'h2000; step(); chk_state("fill2", 16'h2000, 3'd2, 1'b0);
    br_addr = 16'h3000; step(); chk_state("fill3", 16'h3000, 3'd3, 1'b0);
    br_addr = 16'h4000; step(); chk_state("fill4", 16'h4000, 3'd4, 1'b0);
    br_addr = 16'h0300; step(); chk_state("overflow", 16'h0300, 3'd4, 1'b1);
    call = 1'b0;

    // err_clr honoured while held
    pc_en = 1'b0; err_clr = 1'b1;
    step(); chk_state("errclr_hold", 16'h0300, 3'd4, 1'b0);
    pc_en = 1'b1; err_clr = 1'b0;

    // Drain and underflow
    ret = 1'b1;
    step(); chk_state("pop1", 16'h3001, 3'd3, 1'b0);
    step(); chk_state("pop2", 16'h2001, 3'd2, 1'b0);
    step(); chk_state("pop3", 16'h1001, 3'd1, 1'b0);
    step(); chk_state("pop4", 16'h0012, 3'd0, 1'b0);
    step(); chk_state("underflow", 16'h0013, 3'd0, 1'b1);
    ret = 1'b0;

    // Priority: ret beats call and branch
    br_taken = 1'b1; br_addr = 16'h0041; err_clr = 1'b1;
    step(); chk_state("br0041", 16'h0041, 3'd0, 1'b0);
    br_taken = 1'b0; err_clr = 1'b0; call = 1'b1; br_addr = 16'h0500;
    step(); chk_state("call0500", 16'h0500, 3'd1, 1'b0);
    ret = 1'b1; br_taken = 1'b1; br_addr = 16'h0777;
    step(); chk_state("all3", 16'h0042, 3'd0, 1'b0);
    call = 1'b0; br_taken = 1'b0; err_clr = 1'b1;
    step(); chk_state("clr_vs_uf", 16'h0043, 3'd0, 1'b1);
    ret = 1'b0; err_clr = 1'b0;

    // Hold with call asserted
    pc_en = 1'b0; call = 1'b1; br_addr = 16'h0888;
    step(); chk_state("hold1", 16'h0043, 3'd0, 1'b1);
    step(); chk_state("hold2", 16'h0043, 3'd0, 1'b1);
    pc_en = 1'b1; call = 1'b0;

    // Wrap
    br_taken = 1'b1; br_addr = 16'hFFFF;
    step(); chk_state("brFFFF", 16'hFFFF, 3'd0, 1'b1);
    br_taken = 1'b0;
    step(); chk_state("wrap", 16'h0000, 3'd0, 1'b1);
    br_taken = 1'b1; br_addr = 16'hFFFF;
    step(); chk_state("brFFFF2", 16'hFFFF, 3'd0, 1'b1);
    br_taken = 1'b0; call = 1'b1; br_addr = 16'h0123;
    step(); chk_state("callFFFF", 16'h0123, 3'd1, 1'b1);
    call = 1'b0; ret = 1'b1;
    step(); chk_state("retwrap", 16'h0000, 3'd0, 1'b1);
    ret = 1'b0;

    // Async reset mid-stack
    call = 1'b1;
    br_addr = 16'h0A00; step();
    br_addr = 16'h0B00; step();
    br_addr = 16'h0C00; step(); chk_state("depth3", 16'h0C00, 3'd3, 1'b1);
    call = 1'b0; ret = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 16'h0000, 3'd0, 1'b0);
    rst = 1'b0;
    step(); chk_state("post_rst_uf", 16'h0001, 3'd0, 1'b1);
    ret = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
